// File: rtl/ct_f_spsram_sliced_init.sv
// ============================================================================
// Module   : ct_f_spsram_sliced_init
// Brief    : Sliced single-port SRAM wrapper with a hardware init sweep after
//            reset. Optional Q output register: CT_F_SPSRAM_OUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_f_spsram_sliced_init #(
  parameter int                   ADDR_WIDTH = 9,
  parameter int                   DATA_WIDTH = 54,
  parameter int                   WRAP_SIZE  = 27,
  parameter int                   INIT_EN    = 1,
  parameter logic [WRAP_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE
);

  localparam int NUM_SLICES = DATA_WIDTH / WRAP_SIZE;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of WRAP_SIZE");
  end

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic                    q_vld_q, q_vld_d;
  logic                    in_init;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_dout;
  logic                    wen_unused;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      q_vld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      q_vld_q     <= q_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        cnt_d   = '0;
        state_d = (INIT_EN != 0) ? ST_INIT : ST_READY;
      end
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign in_init   = (state_q == ST_INIT);
  assign INIT_DONE = (state_q == ST_READY);
  assign accept    = INIT_DONE && !CEN;

  // Holding the last accepted address keeps Q stable while the array is idle.
  assign addr_hold_d = accept ? A : addr_hold_q;
  assign q_vld_d     = q_vld_q | accept;
  assign ram_addr    = in_init ? cnt_q : (CEN ? addr_hold_q : A);

  // Only the top WEN bit of each slice is a real enable.
  assign wen_unused  = ^WEN;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    logic [WRAP_SIZE-1:0] mem [DEPTH];
    logic [WRAP_SIZE-1:0] dout_q;
    logic                 we;
    logic [WRAP_SIZE-1:0] wdata;

    assign we    = in_init | (accept & !GWEN & !WEN[(i+1)*WRAP_SIZE-1]);
    assign wdata = in_init ? INIT_VALUE : D[i*WRAP_SIZE +: WRAP_SIZE];

    always_ff @(posedge CLK) begin
      if (we) begin
        mem[ram_addr] <= wdata;
      end
      dout_q <= mem[ram_addr];
    end

    assign ram_dout[i*WRAP_SIZE +: WRAP_SIZE] = dout_q;
  end

`ifdef CT_F_SPSRAM_OUT_REG_EN
  logic                  acc_d1_q, acc_d1_d;
  logic [DATA_WIDTH-1:0] q_out_q, q_out_d;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      acc_d1_q <= 1'b0;
      q_out_q  <= '0;
    end else begin
      acc_d1_q <= acc_d1_d;
      q_out_q  <= q_out_d;
    end
  end

  always_comb begin
    acc_d1_d = accept;
    q_out_d  = q_out_q;
    if (acc_d1_q && q_vld_q) begin
      q_out_d = ram_dout;
    end
  end

  assign Q = q_out_q;
`else
  assign Q = q_vld_q ? ram_dout : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ct_f_spsram_sliced_init.sv
// ============================================================================
// Module   : tb_ct_f_spsram_sliced_init
// Brief    : Self-checking bench: vector table plus scoreboard of expected Q.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_f_spsram_sliced_init;

  localparam int AW = 9;
  localparam int DW = 54;
`ifdef CT_F_SPSRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] PAT  = 54'h2A_5A5A_5A5A_5A5A;

  logic          CLK = 1'b0;
  logic          cpurst_b = 1'b0;
  logic [AW-1:0] A = '0;
  logic          CEN = 1'b1;
  logic          GWEN = 1'b1;
  logic [DW-1:0] D = '0;
  logic [DW-1:0] WEN = '1;
  logic [DW-1:0] Q;
  logic          INIT_DONE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            due_q [$];
  logic [DW-1:0] exp_q [$];
  int            tag_q [$];

  typedef struct packed {
    logic          cen;
    logic          gwen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] wen;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  ct_f_spsram_sliced_init dut (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .A        (A),
    .CEN      (CEN),
    .GWEN     (GWEN),
    .D        (D),
    .WEN      (WEN),
    .Q        (Q),
    .INIT_DONE(INIT_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: pop every expectation whose due cycle has arrived.
  always @(negedge CLK) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      check($sformatf("q_tag%0d", tag_q[0]), {10'd0, Q}, {10'd0, exp_q[0]});
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
  end

  function automatic vec_t mk(input logic cen, input logic gwen, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] wen,
                              input logic chk, input logic [DW-1:0] exp);
    vec_t v;
    v.cen = cen; v.gwen = gwen; v.a = a; v.d = d; v.wen = wen; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of stimulus at the current negedge, then move to the next.
  task automatic apply(input vec_t v, input int tag);
    CEN  = v.cen;
    GWEN = v.gwen;
    A    = v.a;
    D    = v.d;
    WEN  = v.wen;
    if (v.chk) begin
      due_q.push_back(cyc + LAT);
      exp_q.push_back(v.exp);
      tag_q.push_back(tag);
    end
    @(negedge CLK);
  endtask

  task automatic drain_and_check(input string name);
    repeat (LAT + 2) apply(mk(1'b1, 1'b1, '0, '0, '1, 1'b0, '0), 0);
    check(name, 64'(due_q.size()), 64'd0);
    due_q.delete();
    exp_q.delete();
    tag_q.delete();
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 9'h1FF, '0,                  '0,                 1'b1, '0);
    vecs[1]  = mk(1'b0, 1'b0, 9'h005, PAT,                 '0,                 1'b0, '0);
    vecs[2]  = mk(1'b0, 1'b1, 9'h005, '0,                  '0,                 1'b1, PAT);
    vecs[3]  = mk(1'b0, 1'b0, 9'h010, ONES,                54'h4000000,        1'b0, '0);
    vecs[4]  = mk(1'b0, 1'b1, 9'h010, '0,                  '0,                 1'b1, 54'h3FFFFFF8000000);
    vecs[5]  = mk(1'b1, 1'b0, 9'h020, ONES,                '0,                 1'b1, 54'h3FFFFFF8000000);
    vecs[6]  = mk(1'b0, 1'b1, 9'h020, '0,                  '0,                 1'b1, '0);
    vecs[7]  = mk(1'b0, 1'b0, 9'h010, 54'h15555555555555,  54'h20000000000000, 1'b0, '0);
    vecs[8]  = mk(1'b0, 1'b1, 9'h010, '0,                  '0,                 1'b1, 54'h3FFFFFFD555555);
    vecs[9]  = mk(1'b0, 1'b0, 9'h1FF, 54'h0ABCDEF0123456,  54'h1FFFFFFBFFFFFF, 1'b0, '0);
    vecs[10] = mk(1'b0, 1'b1, 9'h1FF, '0,                  '0,                 1'b1, 54'h0ABCDEF0123456);
    vecs[11] = mk(1'b0, 1'b1, 9'h005, '0,                  '0,                 1'b1, PAT);
    vecs[12] = mk(1'b0, 1'b1, 9'h005, '0,                  '0,                 1'b1, PAT);
    vecs[13] = mk(1'b0, 1'b1, 9'h000, '0,                  '0,                 1'b1, '0);

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_init_done", {63'd0, INIT_DONE}, 64'd0);
    check("rst_q", {10'd0, Q}, 64'd0);

    // T1: sweep length after release
    cpurst_b = 1'b1;
    for (int k = 1; k <= 513; k++) begin
      @(negedge CLK);
      check($sformatf("t1_init_done_k%0d", k), {63'd0, INIT_DONE}, (k >= 513) ? 64'd1 : 64'd0);
    end
    check("t1_q_before_access", {10'd0, Q}, 64'd0);

    // T1 read, T2, T3, T6 and mixed masks from the table
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i], i);
    end

    // T4: Q holds while idle and A wanders
    apply(mk(1'b0, 1'b1, 9'h005, '0, '0, 1'b1, PAT), 40);
    for (int i = 0; i < 10; i++) begin
      apply(mk(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 511)),
               DW'({$urandom, $urandom}), '0, 1'b1, PAT), 41 + i);
    end
    drain_and_check("t4_queue_empty");

    // T5: ignored access mid-sweep, then reset at cnt=200 restarts the sweep
    cpurst_b = 1'b0;
    repeat (2) @(negedge CLK);
    check("t5_rst_init_done", {63'd0, INIT_DONE}, 64'd0);
    check("t5_rst_q", {10'd0, Q}, 64'd0);
    cpurst_b = 1'b1;
    for (int k = 1; k <= 201; k++) begin
      @(negedge CLK);
      if (k == 101) begin
        CEN = 1'b0; GWEN = 1'b0; A = 9'h003; D = ONES; WEN = '0;
      end else begin
        CEN = 1'b1; GWEN = 1'b1;
      end
    end
    check("t5_mid_init_done", {63'd0, INIT_DONE}, 64'd0);
    cpurst_b = 1'b0;
    repeat (2) @(negedge CLK);
    check("t5_rst2_init_done", {63'd0, INIT_DONE}, 64'd0);
    cpurst_b = 1'b1;
    for (int k = 1; k <= 513; k++) begin
      @(negedge CLK);
      check($sformatf("t5_init_done_k%0d", k), {63'd0, INIT_DONE}, (k >= 513) ? 64'd1 : 64'd0);
      if (k <= 512) begin
        CEN = 1'b0; GWEN = 1'b0; A = 9'h003; D = ONES; WEN = '0;
      end else begin
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0;
      end
    end
    check("t5_q_after_init", {10'd0, Q}, 64'd0);
    apply(mk(1'b0, 1'b1, 9'h003, '0, '0, 1'b1, '0), 60);
    apply(mk(1'b0, 1'b1, 9'h005, '0, '0, 1'b1, '0), 61);
    apply(mk(1'b0, 1'b1, 9'h010, '0, '0, 1'b1, '0), 62);
    drain_and_check("t5_queue_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
